// File: rtl/uart_frame_pkg.sv
// Shared constants and state encodings for the framed UART receiver.
package uart_frame_pkg;

  localparam logic [7:0] HDR_BYTE         = 8'hAA;
  localparam logic [7:0] TRL_BYTE         = 8'hBB;
  localparam int         CLKS_PER_BIT_DEF = 52;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } byte_state_e;

  typedef enum logic [2:0] {
    HDR = 3'd0,
    B3  = 3'd1,
    B2  = 3'd2,
    B1  = 3'd3,
    B0  = 3'd4,
    TRL = 3'd5
  } frame_state_e;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: two-flop synchronizer, start-edge detect and mid-bit sampling.
module uart_byte_rx
  import uart_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       byte_done,
  output logic       stop_err,
  output logic       idle
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1_q, sync2_q, prev_q;
  byte_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;

  // Synchronize the raw line and keep its previous value for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Byte FSM and bit-timing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state logic; each sample is taken when the countdown reaches zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    byte_done = 1'b0;
    stop_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = START;
          cnt_d   = HALF;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!sync2_q) begin
            state_d = DATA;
            cnt_d   = FULL;
            bit_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {sync2_q, shreg_q[7:1]};
          cnt_d   = FULL;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          byte_done = sync2_q;
          stop_err  = !sync2_q;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data = shreg_q;
  assign idle = (state_q == IDLE);

endmodule

// File: rtl/uart_frame_rx.sv
// Frame decoder: AA, four payload bytes (MSB first), BB; aborts on bad trailer, stop error or gap timeout.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int TIMEOUT_CLKS = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [31:0] value,
  output logic        value_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int            GW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CLKS - 1);

  logic [7:0]    rx_data;
  logic          byte_done, stop_err, byte_idle;

  frame_state_e  state_q, state_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   value_q, value_d;
  logic          value_valid_q, value_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [GW-1:0] gap_q, gap_d;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .data     (rx_data),
    .byte_done(byte_done),
    .stop_err (stop_err),
    .idle     (byte_idle)
  );

  // Frame state, payload shadow, published value, pulses and gap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HDR;
      shadow_q      <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      frame_err_q   <= frame_err_d;
      gap_q         <= gap_d;
    end
  end

  // Frame sequencing; a received byte takes priority over abort conditions.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    gap_d         = gap_q;

    if (state_q == HDR || byte_done) begin
      gap_d = '0;
    end else if (byte_idle) begin
      gap_d = gap_q + 1'b1;
    end

    if (byte_done) begin
      case (state_q)
        HDR: if (rx_data == HDR_BYTE) state_d = B3;
        B3: begin shadow_d[31:24] = rx_data; state_d = B2;  end
        B2: begin shadow_d[23:16] = rx_data; state_d = B1;  end
        B1: begin shadow_d[15:8]  = rx_data; state_d = B0;  end
        B0: begin shadow_d[7:0]   = rx_data; state_d = TRL; end
        TRL: begin
          if (rx_data == TRL_BYTE) begin
            value_d       = shadow_q;
            value_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = HDR;
        end
        default: state_d = HDR;
      endcase
    end else if (stop_err) begin
      if (state_q != HDR) begin
        frame_err_d = 1'b1;
        state_d     = HDR;
      end
    end else if (state_q != HDR && byte_idle && gap_q == GAP_LAST) begin
      frame_err_d = 1'b1;
      state_d     = HDR;
    end
  end

  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q != HDR);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx with a value scoreboard.
module tb_uart_frame_rx;

  localparam int CPB = 52;
  localparam int TO  = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic [31:0] value;
  logic        value_valid, frame_err, busy;

  int          tests = 0;
  int          fails = 0;
  int          vv_cnt = 0;
  int          fe_cnt = 0;
  logic        vv_prev = 1'b0;
  logic        fe_prev = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  uart_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (uart_rx),
    .value      (value),
    .value_valid(value_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Scoreboard monitor: every value_valid pops an expected value.
  always @(negedge clk) begin
    if (value_valid) begin
      vv_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_valid: value=%h with no expected entry", value);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (value !== e) begin
          fails++;
          $display("FAIL sb_value: got %h want %h", value, e);
        end
      end
      tests++;
      if (vv_prev) begin
        fails++;
        $display("FAIL valid_pulse_width: value_valid high 2+ cycles, want 1");
      end
    end
    if (frame_err) begin
      fe_cnt++;
      tests++;
      if (fe_prev || value_valid) begin
        fails++;
        $display("FAIL err_pulse: frame_err=%b prev=%b valid=%b, want single pulse alone", frame_err, fe_prev, value_valid);
      end
    end
    vv_prev = value_valid;
    fe_prev = frame_err;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] v, input logic [7:0] trl);
    send_byte(8'hAA, 1'b1);
    send_byte(v[31:24], 1'b1);
    send_byte(v[23:16], 1'b1);
    send_byte(v[15:8], 1'b1);
    send_byte(v[7:0], 1'b1);
    send_byte(trl, 1'b1);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (value !== 32'h0 || value_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: value=%h vv=%b fe=%b busy=%b, want all 0", value, value_valid, frame_err, busy);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || value !== 32'h0) begin
      fails++;
      $display("FAIL reset_release: value=%h busy=%b, want 0/0", value, busy);
    end
  endtask

  task automatic test_basic();
    int vv0, fe0;
    vv0 = vv_cnt; fe0 = fe_cnt;
    exp_q.push_back(32'h0000_0100);
    send_frame(32'h0000_0100, 8'hBB);
    tests++;
    if (vv_cnt - vv0 != 1 || fe_cnt - fe0 != 0) begin
      fails++;
      $display("FAIL basic_counts: valid=%0d err=%0d, want 1/0", vv_cnt - vv0, fe_cnt - fe0);
    end
    tests++;
    if (value !== 32'h0000_0100 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_value: value=%h busy=%b, want 00000100/0", value, busy);
    end
  endtask

  task automatic test_discard();
    int vv0;
    vv0 = vv_cnt;
    send_byte(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL discard_busy: busy=%b after 0x55, want 0", busy);
    end
    exp_q.push_back(32'h1234_5678);
    send_frame(32'h1234_5678, 8'hBB);
    tests++;
    if (vv_cnt - vv0 != 1 || value !== 32'h1234_5678) begin
      fails++;
      $display("FAIL discard_value: valid=%0d value=%h, want 1/12345678", vv_cnt - vv0, value);
    end
  endtask

  task automatic test_bad_trailer();
    int vv0, fe0;
    vv0 = vv_cnt; fe0 = fe_cnt;
    send_frame(32'h1122_3344, 8'hCC);
    tests++;
    if (fe_cnt - fe0 != 1 || vv_cnt - vv0 != 0) begin
      fails++;
      $display("FAIL badtrl_counts: err=%0d valid=%0d, want 1/0", fe_cnt - fe0, vv_cnt - vv0);
    end
    tests++;
    if (value !== 32'h1234_5678 || busy !== 1'b0) begin
      fails++;
      $display("FAIL badtrl_value: value=%h busy=%b, want 12345678/0", value, busy);
    end
  endtask

  task automatic test_glitch();
    int vv0, fe0;
    vv0 = vv_cnt; fe0 = fe_cnt;
    uart_rx = 1'b0;
    repeat (10) @(negedge clk);
    uart_rx = 1'b1;
    repeat (100) @(negedge clk);
    tests++;
    if (fe_cnt - fe0 != 0 || vv_cnt - vv0 != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL glitch_quiet: err=%0d valid=%0d busy=%b, want 0/0/0", fe_cnt - fe0, vv_cnt - vv0, busy);
    end
    exp_q.push_back(32'hDEAD_BEEF);
    send_frame(32'hDEAD_BEEF, 8'hBB);
    tests++;
    if (value !== 32'hDEAD_BEEF || vv_cnt - vv0 != 1) begin
      fails++;
      $display("FAIL glitch_frame: value=%h valid=%0d, want DEADBEEF/1", value, vv_cnt - vv0);
    end
  endtask

  task automatic test_stop_err();
    int fe0;
    fe0 = fe_cnt;
    send_byte(8'hAA, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b0);
    repeat (30) @(negedge clk);
    tests++;
    if (fe_cnt - fe0 != 1 || busy !== 1'b0 || value !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL stoperr: err=%0d busy=%b value=%h, want 1/0/DEADBEEF", fe_cnt - fe0, busy, value);
    end
  endtask

  task automatic test_timeout();
    int fe0, n;
    bit found;
    fe0 = fe_cnt; n = 0; found = 1'b0;
    send_byte(8'hAA, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL timeout_busy_before: busy=%b, want 1", busy);
    end
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (!found && frame_err) begin
        found = 1'b1;
        n = i;
      end
    end
    tests++;
    if (!found || n < TO - 40 || n > TO + 5) begin
      fails++;
      $display("FAIL timeout_time: found=%b at %0d clks, want within [%0d,%0d]", found, n, TO - 40, TO + 5);
    end
    tests++;
    if (fe_cnt - fe0 != 1 || busy !== 1'b0 || value !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL timeout_after: err=%0d busy=%b value=%h, want 1/0/DEADBEEF", fe_cnt - fe0, busy, value);
    end
  endtask

  task automatic test_reset_mid();
    int fe0, vv0;
    fe0 = fe_cnt;
    send_byte(8'hAA, 1'b1);
    send_byte(8'h01, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (value !== 32'h0 || value_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_outputs: value=%h vv=%b fe=%b busy=%b, want all 0", value, value_valid, frame_err, busy);
    end
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    tests++;
    if (fe_cnt - fe0 != 0) begin
      fails++;
      $display("FAIL midreset_err: err=%0d, want 0", fe_cnt - fe0);
    end
    vv0 = vv_cnt;
    exp_q.push_back(32'h0A0B_0C0D);
    send_frame(32'h0A0B_0C0D, 8'hBB);
    tests++;
    if (value !== 32'h0A0B_0C0D || vv_cnt - vv0 != 1) begin
      fails++;
      $display("FAIL midreset_frame: value=%h valid=%0d, want 0A0B0C0D/1", value, vv_cnt - vv0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_discard();
    test_bad_trailer();
    test_glitch();
    test_stop_err();
    test_timeout();
    test_reset_mid();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d expected values never produced, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, 52, clk cycles per UART bit (>=8).
REQ-002 SHALL have parameter TIMEOUT_CLKS, 20000, max idle clks between bytes inside a frame.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port uart_rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port value  output  32  last good frame payload, big-endian.
REQ-007 SHALL have port value_valid  output  1  one-cycle pulse when value updates.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on any frame abort.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress past header.

Function
REQ-010 SHALL pass uart_rx through a 2-flop synchronizer (reset value 1) before any use.
REQ-011 SHALL define frame: 0xAA, byte3 (value[31:24]), byte2, byte1, byte0 (value[7:0]), 0xBB; each byte 8N1, LSB first.
REQ-012 Byte FSM SHALL use states IDLE, START, DATA, STOP.
REQ-013 IDLE->START on synchronized 1->0 transition; bit counter loaded for half-bit (CLKS_PER_BIT/2).
REQ-014 START: at half-bit, line low -> DATA; line high -> IDLE (glitch rejected, no error).
REQ-015 DATA: sample 8 bits, each CLKS_PER_BIT after the previous sample point, shift in LSB first.
REQ-016 STOP: sample CLKS_PER_BIT later; high -> byte_done pulse; low -> stop_err pulse; both return to IDLE immediately (mid-stop), allowing back-to-back bytes.
REQ-017 Frame FSM SHALL use states HDR, B3, B2, B1, B0, TRL.
REQ-018 HDR: byte 0xAA -> B3; any other byte silently discarded, stay HDR.
REQ-019 B3..B0: each byte_done stores byte into payload shadow register, advance one state.
REQ-020 TRL: byte 0xBB -> copy shadow to value, pulse value_valid next cycle, -> HDR; other byte -> frame_err, -> HDR, value unchanged.
REQ-021 stop_err in any state other than HDR SHALL pulse frame_err and -> HDR; in HDR it SHALL be ignored.
REQ-022 Gap counter SHALL reset on byte_done and count while byte FSM in IDLE and frame FSM not HDR; reaching TIMEOUT_CLKS -> frame_err, -> HDR.
REQ-023 value_valid and frame_err SHALL be registered, asserted exactly the cycle after the triggering byte_done/stop_err/timeout, never both high.
REQ-024 value SHALL change only on a good trailer; shadow contents of aborted frames never reach value.
REQ-025 busy SHALL be high in B3..TRL, low in HDR.
REQ-026 Latency: value_valid asserts 2 clks (sync) + 1 clk after trailer mid-stop sample, within 3 clks.
REQ-027 Counters SHALL be sized for CLKS_PER_BIT and TIMEOUT_CLKS without wrap.

Reset
REQ-028 rst_n low SHALL asynchronously force: sync flops 1, byte FSM IDLE, frame FSM HDR, counters 0, value 0, value_valid 0, frame_err 0, busy 0.
REQ-029 Reset mid-frame SHALL discard partial data with no frame_err pulse; first frame after release SHALL decode normally.

Structure
REQ-030 Package uart_frame_pkg SHALL hold HDR_BYTE 0xAA, TRL_BYTE 0xBB, default CLKS_PER_BIT, byte and frame state encodings.
REQ-031 Sub-module uart_byte_rx SHALL contain synchronizer and byte FSM, outputting data[7:0], byte_done, stop_err.
REQ-032 Top SHALL contain frame FSM, shadow register, gap counter, outputs.

Verification
REQ-033 Bytes AA 00 00 01 00 BB at CLKS_PER_BIT=52 -> value=0x00000100, value_valid one cycle, frame_err never.
REQ-034 Bytes 55 AA 12 34 56 78 BB -> 0x55 discarded, value=0x12345678, one value_valid.
REQ-035 After good frame 0x12345678, send AA 11 22 33 44 CC -> frame_err one cycle, value stays 0x12345678.
REQ-036 Low glitch of 10 clks on idle line, then good frame AA DE AD BE EF BB -> no byte from glitch, value=0xDEADBEEF.
REQ-037 AA 01 02 then stop bit forced 0 on next byte -> frame_err; AA 01 02 then 30000 idle clks -> frame_err at gap 20000, busy falls.
REQ-038 rst_n pulsed after AA 01 -> all outputs 0, no frame_err; following AA 0A 0B 0C 0D BB -> value=0x0A0B0C0D.
